// File: rtl/mem_access_ctrl_pkg.sv
// Shared codes for the memory access sequencer.
//   - load kinds (l_type) and store kinds (s_type) as issued by the CPU control FSM
//   - FSM state encoding
//   - access_err(): alignment / illegal-kind check applied when a request is accepted
package mem_access_ctrl_pkg;

    // Load kinds
    localparam logic [2:0] LD_WORD  = 3'd0;
    localparam logic [2:0] LD_HALF  = 3'd1;
    localparam logic [2:0] LD_HALFU = 3'd2;
    localparam logic [2:0] LD_BYTE  = 3'd3;
    localparam logic [2:0] LD_BYTEU = 3'd4;

    // Store kinds
    localparam logic [1:0] ST_WORD  = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_BYTE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // True when the access is misaligned for its size or names an unknown kind.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] l_type,
                                        input logic [1:0] s_type,
                                        input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        if (we) begin
            case (s_type)
                ST_WORD: err = (addr_lo != 2'b00);
                ST_HALF: err = addr_lo[0];
                ST_BYTE: err = 1'b0;
                default: err = 1'b1;
            endcase
        end else begin
            case (l_type)
                LD_WORD:           err = (addr_lo != 2'b00);
                LD_HALF, LD_HALFU: err = addr_lo[0];
                LD_BYTE, LD_BYTEU: err = 1'b0;
                default:           err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between CPU control FSM, the access sequencer and data memory.
//   CPU side : cpu_req, cpu_we, l_type, s_type, addr, wdata -> sequencer
//              cpu_done, rdata, busy, adel, ades, timeout   <- sequencer
//   Mem side : mem_req, mem_we, mem_addr, mem_be, mem_wdata <- sequencer
//              mem_rdata, mem_ready                         -> sequencer
// Modports: slave = the sequencer, master = its environment (CPU + memory).
interface mem_access_ctrl_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  l_type;
    logic [1:0]  s_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cpu_done;
    logic [31:0] rdata;
    logic        busy;
    logic        adel;
    logic        ades;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  cpu_req, cpu_we, l_type, s_type, addr, wdata, mem_rdata, mem_ready,
        output cpu_done, rdata, busy, adel, ades, timeout,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, l_type, s_type, addr, wdata, mem_rdata, mem_ready,
        input  cpu_done, rdata, busy, adel, ades, timeout,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_access_ctrl_ld_extend.sv
// Load data extraction: picks the addressed half/byte out of a memory word and
// sign- or zero-extends it to 32 bits.
//   l_type  in  3   load kind
//   addr_lo in  2   byte offset within the word
//   word    in  32  raw memory word
//   result  out 32  extended load value
module mem_access_ctrl_ld_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  l_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        result   = word;
        case (l_type)
            LD_HALF:  result = {{16{half_sel[15]}}, half_sel};
            LD_HALFU: result = {16'h0000, half_sel};
            LD_BYTE:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_BYTEU: result = {24'h000000, byte_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the multicycle CPU control FSM and a
// synchronous data memory. One access per cpu_req; misaligned or illegal
// accesses are rejected without touching memory; a memory that never answers
// is abandoned after TIMEOUT_CYCLES request cycles.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    slave modport of mem_access_ctrl_if (CPU and memory signals)
// All outputs are registered.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [2:0]          ltype_q;
    logic [1:0]          addr_lo_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [31:0]         mem_wdata_q;
    logic [31:0]         rdata_q;
    logic                done_q;
    logic                busy_q;
    logic                adel_q;
    logic                ades_q;
    logic                tmo_q;

    logic [3:0]          mem_be_d;
    logic [31:0]         mem_wdata_d;
    logic [31:0]         ld_result;

    // Store lane placement from the live request; captured on the accept edge.
    always_comb begin
        mem_be_d    = 4'b1111;
        mem_wdata_d = 32'h0000_0000;
        if (bus.cpu_we) begin
            case (bus.s_type)
                ST_HALF: begin
                    mem_be_d    = bus.addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata_d = {2{bus.wdata[15:0]}};
                end
                ST_BYTE: begin
                    mem_be_d    = 4'b0001 << bus.addr[1:0];
                    mem_wdata_d = {4{bus.wdata[7:0]}};
                end
                default: begin
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = bus.wdata;
                end
            endcase
        end
    end

    mem_access_ctrl_ld_extend u_ld_extend (
        .l_type  (ltype_q),
        .addr_lo (addr_lo_q),
        .word    (bus.mem_rdata),
        .result  (ld_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the register set is small and has no storage arrays, so every flop is reset; mem_req drops the moment reset asserts.
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ltype_q     <= 3'd0;
            addr_lo_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            // Completion flags are single-cycle pulses.
            done_q <= 1'b0;
            adel_q <= 1'b0;
            ades_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        we_q      <= bus.cpu_we;
                        ltype_q   <= bus.l_type;
                        addr_lo_q <= bus.addr[1:0];
                        busy_q    <= 1'b1;
                        if (access_err(bus.cpu_we, bus.l_type, bus.s_type, bus.addr[1:0])) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            adel_q  <= ~bus.cpu_we;
                            ades_q  <= bus.cpu_we;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= {bus.addr[31:2], 2'b00};
                            mem_be_q    <= mem_be_d;
                            mem_wdata_q <= mem_wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= ld_result;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Last allowed request cycle passed without ready: abandon.
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        tmo_q     <= 1'b1;
                        rdata_q   <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_done  = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.adel      = adel_q;
    assign bus.ades      = ades_q;
    assign bus.timeout   = tmo_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT_CYCLES=4. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_mem_access_ctrl;

    import mem_access_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge (the accept edge) and returns 1ns after it.
    task automatic issue(input logic we, input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.cpu_we  = we;
        bus.l_type  = lt;
        bus.s_type  = st;
        bus.addr    = a;
        bus.wdata   = wd;
        bus.cpu_req = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
    endtask

    // Load answered on the first REQ cycle; checks result and return to idle.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
        issue(1'b0, lt, ST_WORD, a, 32'h0);
        check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, "_be"}, {28'h0, bus.mem_be}, 32'hF);
        bus.mem_rdata = word;
        bus.mem_ready = 1'b1;
        tick();
        check({tag, "_done"}, {31'h0, bus.cpu_done}, 32'h1);
        check({tag, "_rdata"}, bus.rdata, exp);
        bus.mem_ready = 1'b0;
        tick();
    endtask

    // Rejected access: error pulse one edge after accept, memory untouched.
    task automatic do_err(input string tag, input logic we, input logic [2:0] lt,
                          input logic [1:0] st, input logic [31:0] a);
        issue(we, lt, st, a, 32'h1234_5678);
        check({tag, "_done"}, {31'h0, bus.cpu_done}, 32'h1);
        check({tag, "_adel"}, {31'h0, bus.adel}, {31'h0, ~we});
        check({tag, "_ades"}, {31'h0, bus.ades}, {31'h0, we});
        check({tag, "_req"}, {31'h0, bus.mem_req}, 32'h0);
        check({tag, "_rdata"}, bus.rdata, 32'h0);
        tick();
        check({tag, "_req2"}, {31'h0, bus.mem_req}, 32'h0);
        check({tag, "_idle"}, {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        int req_cycles;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.l_type    = 3'd0;
        bus.s_type    = 2'd0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset state
        #12;
        check("rst_done", {31'h0, bus.cpu_done}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_be", {28'h0, bus.mem_be}, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b1;
        tick();

        // mem_ready in IDLE is ignored
        bus.mem_ready = 1'b1;
        tick();
        check("idle_rdy_done", {31'h0, bus.cpu_done}, 32'h0);
        check("idle_rdy_busy", {31'h0, bus.busy}, 32'h0);
        bus.mem_ready = 1'b0;

        // lw 0x10 with latency check; cpu_req held during REQ is ignored
        issue(1'b0, LD_WORD, ST_WORD, 32'h0000_0010, 32'h0);
        check("lw_req", {31'h0, bus.mem_req}, 32'h1);
        check("lw_we", {31'h0, bus.mem_we}, 32'h0);
        check("lw_addr", bus.mem_addr, 32'h0000_0010);
        check("lw_be", {28'h0, bus.mem_be}, 32'hF);
        check("lw_wdata", bus.mem_wdata, 32'h0);
        check("lw_busy", {31'h0, bus.busy}, 32'h1);
        check("lw_done_n1", {31'h0, bus.cpu_done}, 32'h0);
        bus.cpu_req   = 1'b1;
        bus.addr      = 32'h0000_0099;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_ready = 1'b1;
        tick();
        bus.cpu_req   = 1'b0;
        bus.mem_ready = 1'b0;
        check("lw_done_n2", {31'h0, bus.cpu_done}, 32'h1);
        check("lw_rdata", bus.rdata, 32'hDEAD_BEEF);
        check("lw_req_off", {31'h0, bus.mem_req}, 32'h0);
        check("lw_tmo", {31'h0, bus.timeout}, 32'h0);
        tick();
        check("lw_done_pulse", {31'h0, bus.cpu_done}, 32'h0);
        check("lw_busy_off", {31'h0, bus.busy}, 32'h0);
        check("lw_no_adel", {31'h0, bus.adel}, 32'h0);
        check("lw_rdata_hold", bus.rdata, 32'hDEAD_BEEF);

        // Sub-word loads
        do_load("lb13", LD_BYTE, 32'h0000_0013, 32'h8012_3456, 32'hFFFF_FF80);
        do_load("lbu13", LD_BYTEU, 32'h0000_0013, 32'h8012_3456, 32'h0000_0080);
        do_load("lh12", LD_HALF, 32'h0000_0012, 32'h8012_3456, 32'hFFFF_8012);
        do_load("lhu12", LD_HALFU, 32'h0000_0012, 32'h8012_3456, 32'h0000_8012);
        do_load("lb10", LD_BYTE, 32'h0000_0010, 32'h8012_3456, 32'h0000_0056);
        do_load("lh10", LD_HALF, 32'h0000_0010, 32'h8012_B456, 32'hFFFF_B456);

        // sh 0x22: upper lanes, rdata unchanged by store
        issue(1'b1, LD_WORD, ST_HALF, 32'h0000_0022, 32'h1234_ABCD);
        check("sh_req", {31'h0, bus.mem_req}, 32'h1);
        check("sh_we", {31'h0, bus.mem_we}, 32'h1);
        check("sh_addr", bus.mem_addr, 32'h0000_0020);
        check("sh_be", {28'h0, bus.mem_be}, 32'hC);
        check("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        bus.mem_rdata = 32'h7777_7777;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("sh_done", {31'h0, bus.cpu_done}, 32'h1);
        check("sh_rdata_keep", bus.rdata, 32'hFFFF_B456);
        tick();

        // sb 0x21
        issue(1'b1, LD_WORD, ST_BYTE, 32'h0000_0021, 32'h0000_0055);
        check("sb_be", {28'h0, bus.mem_be}, 32'h2);
        check("sb_wdata", bus.mem_wdata, 32'h5555_5555);
        check("sb_addr", bus.mem_addr, 32'h0000_0020);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("sb_done", {31'h0, bus.cpu_done}, 32'h1);
        tick();

        // sw 0x24 and sh at lower lanes
        issue(1'b1, LD_WORD, ST_WORD, 32'h0000_0024, 32'hA5A5_0F0F);
        check("sw_be", {28'h0, bus.mem_be}, 32'hF);
        check("sw_wdata", bus.mem_wdata, 32'hA5A5_0F0F);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        issue(1'b1, LD_WORD, ST_HALF, 32'h0000_0030, 32'hFFFF_1357);
        check("sh30_be", {28'h0, bus.mem_be}, 32'h3);
        check("sh30_wdata", bus.mem_wdata, 32'h1357_1357);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();

        // Rejected accesses
        do_err("lw06", 1'b0, LD_WORD, ST_WORD, 32'h0000_0006);
        do_err("sh01", 1'b1, LD_WORD, ST_HALF, 32'h0000_0001);
        do_err("lt5", 1'b0, 3'd5, ST_WORD, 32'h0000_0000);
        do_err("st3", 1'b1, LD_WORD, 2'd3, 32'h0000_0000);

        // Restore nonzero rdata, then timeout must clear it
        do_load("pre_tmo", LD_WORD, 32'h0000_0040, 32'h0BAD_F00D, 32'h0BAD_F00D);
        issue(1'b0, LD_WORD, ST_WORD, 32'h0000_0044, 32'h0);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cpu_done) break;
            if (bus.mem_req) req_cycles++;
            tick();
        end
        check("tmo_req_cycles", req_cycles, 32'd4);
        check("tmo_done", {31'h0, bus.cpu_done}, 32'h1);
        check("tmo_flag", {31'h0, bus.timeout}, 32'h1);
        check("tmo_rdata", bus.rdata, 32'h0);
        check("tmo_req_off", {31'h0, bus.mem_req}, 32'h0);
        bus.mem_rdata = 32'hFFFF_FFFF;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("tmo_late_done", {31'h0, bus.cpu_done}, 32'h0);
        check("tmo_late_rdata", bus.rdata, 32'h0);
        tick();
        check("tmo_late_busy", {31'h0, bus.busy}, 32'h0);

        // Async reset in the middle of REQ
        do_load("pre_rst", LD_WORD, 32'h0000_0050, 32'h1111_2222, 32'h1111_2222);
        issue(1'b0, LD_WORD, ST_WORD, 32'h0000_0054, 32'h0);
        check("mid_req", {31'h0, bus.mem_req}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", {31'h0, bus.mem_req}, 32'h0);
        check("arst_busy", {31'h0, bus.busy}, 32'h0);
        check("arst_rdata", bus.rdata, 32'h0);
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_done", {31'h0, bus.cpu_done}, 32'h0);
        do_load("post_rst_lw", LD_WORD, 32'h0000_0000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer between the multicycle CPU control FSM and the synchronous data memory.
- Accepts one load/store per request and checks address alignment.
- Drives a req/ready handshake to memory and generates byte enables with lane-replicated store data.
- Returns extended load data with a one-cycle done pulse; bounds memory wait with a timeout.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ready before aborting.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load.
- l_type  in  3  load kind: `lword/`lhalf/`lhalfu/`lbyte/`lbyteu.
- s_type  in  2  store kind: `sword/`shalf/`sbyte.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- cpu_done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result.
- busy  out  1  high in every state except IDLE.
- adel  out  1  load address error, pulses with cpu_done.
- ades  out  1  store address error, pulses with cpu_done.
- timeout  out  1  memory timeout, pulses with cpu_done.
- mem_req  out  1  memory request, held until ready.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-placed store data.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  transfer completes on an edge where mem_req & mem_ready.

Behaviour:
- States: IDLE, REQ, DONE, ERR. Register encoding.
- Reset (async, reset=0): state=IDLE, all outputs 0, counter=0; mem_req drops immediately, including mid-transfer. No retry after reset.
- IDLE:
  - On cpu_req=1, latch cpu_we, l_type, s_type, addr, wdata.
  - Error if word access with addr[1:0]!=0, half access with addr[0]!=0, l_type>4 (load), or s_type==3 (store).
  - Error -> ERR; no mem_req is ever issued. Otherwise -> REQ, counter cleared.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_be, mem_wdata are held stable from the latched values.
  - Edge with mem_ready=1: register rdata, -> DONE.
  - Otherwise counter++. When counter reaches TIMEOUT_CYCLES-1 without ready -> DONE with timeout flag set and rdata=0.
  - mem_ready outside REQ is ignored.
- DONE: cpu_done=1 (plus timeout if flagged) for exactly one cycle, then -> IDLE.
- ERR: cpu_done=1 and adel (load) or ades (store) for one cycle; rdata=0; -> IDLE.
- cpu_req in REQ/DONE/ERR is ignored; the CPU re-requests after done.
- Latency: accept edge N; mem_ready at first REQ cycle gives cpu_done in cycle N+2. Error gives cpu_done in cycle N+1.
- Store lanes:
  - sw: be=1111, data=wdata.
  - sh: data={2{wdata[15:0]}}, be=addr[1]?1100:0011.
  - sb: data={4{wdata[7:0]}}, be=0001<<addr[1:0].
- Loads: mem_be=1111, mem_wdata=0.
- Load extraction:
  - half selects bits [31:16] when addr[1]=1, else [15:0].
  - byte selects lane addr[1:0].
  - lhalf/lbyte sign-extend; lhalfu/lbyteu zero-extend.
- rdata holds until the next completion. Stores leave rdata unchanged.

Decomposition:
- constants.v holds the shared codes:
  - loads: `lword=0, `lhalf=1, `lhalfu=2, `lbyte=3, `lbyteu=4.
  - stores: `sword=0, `shalf=1, `sbyte=2.
  - FSM state codes.
- One combinational sub-module, ld_extend (l_type, addr[1:0], word -> extended result), feeds the rdata register.
- Store lane logic stays inline.

Test Plan:
- lw, addr=0x0000_0010, mem_rdata=0xDEAD_BEEF, mem_ready on first REQ cycle -> mem_addr=0x10, be=1111, cpu_done at N+2, rdata=0xDEAD_BEEF.
- lb at addr 0x13 and lbu at addr 0x13, mem_rdata=0x8012_3456 -> rdata=0xFFFF_FF80 and 0x0000_0080; lh at 0x12 -> 0xFFFF_8012.
- sh, addr=0x22, wdata=0x1234_ABCD -> mem_we=1, be=1100, mem_wdata=0xABCD_ABCD; sb at 0x21, wdata=0x55 -> be=0010, mem_wdata=0x5555_5555.
- lw at 0x0000_0006 -> ERR: cpu_done=1, adel=1 at N+1, mem_req never high; sh at 0x01 -> ades=1.
- mem_ready held 0, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then cpu_done=1, timeout=1, rdata=0; later mem_ready pulse ignored.
- reset low during REQ with mem_req=1 -> mem_req, busy fall without a clock edge; after release, IDLE accepts a new lw normally.
